// File: rtl/dispensador_vuelto.sv
// Change dispenser: pays an amount (in 100-colon units) as 500/100 coin strobes,
// greedy by denomination, while tracking the stock left in each hopper.
module dispensador_vuelto #(
  parameter int W             = 8,
  parameter int PULSE_LEN     = 2,
  parameter int GAP_LEN       = 3,
  parameter int STOCK500_INIT = 10,
  parameter int STOCK100_INIT = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] amount,
  input  logic         restock,
  input  logic         fault_clr,
  output logic         coin500,
  output logic         coin100,
  output logic         busy,
  output logic         done,
  output logic         fault,
  output logic [W-1:0] remaining,
  output logic [W-1:0] stock500,
  output logic [W-1:0] stock100
);

  localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHOOSE,
    S_PULSE,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic           sel500_q;
  logic           coin500_q;
  logic           coin100_q;
  logic           busy_q;
  logic           done_q;
  logic           fault_q;
  logic [W-1:0]   remaining_q;
  logic [W-1:0]   stock500_q;
  logic [W-1:0]   stock100_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sel500_q    <= 1'b0;
      coin500_q   <= 1'b0;
      coin100_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      remaining_q <= '0;
      stock500_q  <= W'(STOCK500_INIT);
      stock100_q  <= W'(STOCK100_INIT);
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            remaining_q <= amount;
            if (amount == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_CHOOSE;
              busy_q  <= 1'b1;
            end
          end else if (restock) begin
            stock500_q <= W'(STOCK500_INIT);
            stock100_q <= W'(STOCK100_INIT);
          end
        end

        // Greedy pick; falling back to 100s also covers an exhausted 500 hopper.
        S_CHOOSE: begin
          cnt_q <= '0;
          if (remaining_q >= W'(5) && stock500_q != '0) begin
            sel500_q  <= 1'b1;
            coin500_q <= 1'b1;
            state_q   <= S_PULSE;
          end else if (remaining_q != '0 && stock100_q != '0) begin
            sel500_q  <= 1'b0;
            coin100_q <= 1'b1;
            state_q   <= S_PULSE;
          end else begin
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
            state_q <= S_FAULT;
          end
        end

        S_PULSE: begin
          if (cnt_q == CW'(PULSE_LEN - 1)) begin
            coin500_q <= 1'b0;
            coin100_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_GAP;
            if (sel500_q) begin
              remaining_q <= remaining_q - W'(5);
              stock500_q  <= stock500_q - W'(1);
            end else begin
              remaining_q <= remaining_q - W'(1);
              stock100_q  <= stock100_q - W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_GAP: begin
          if (cnt_q == CW'(GAP_LEN - 1)) begin
            cnt_q <= '0;
            if (remaining_q == '0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_CHOOSE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        S_FAULT: begin
          if (fault_clr) begin
            fault_q     <= 1'b0;
            remaining_q <= '0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          coin500_q <= 1'b0;
          coin100_q <= 1'b0;
        end
      endcase
    end
  end

  assign coin500   = coin500_q;
  assign coin100   = coin100_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign remaining = remaining_q;
  assign stock500  = stock500_q;
  assign stock100  = stock100_q;

endmodule

// File: tb/tb_dispensador_vuelto.sv
// Directed bench for dispensador_vuelto: cycle-exact payout, draining, fault and reset cases.
module tb_dispensador_vuelto;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] amount;
  logic         restock;
  logic         fault_clr;
  logic         coin500;
  logic         coin100;
  logic         busy;
  logic         done;
  logic         fault;
  logic [W-1:0] remaining;
  logic [W-1:0] stock500;
  logic [W-1:0] stock100;

  int checks   = 0;
  int failures = 0;

  // Monotonic activity totals; tests take differences of snapshots.
  int   n500 = 0, n100 = 0, ndone = 0, nboth = 0, nbusy = 0;
  logic p500 = 1'b0, p100 = 1'b0;

  dispensador_vuelto dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .amount    (amount),
    .restock   (restock),
    .fault_clr (fault_clr),
    .coin500   (coin500),
    .coin100   (coin100),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .remaining (remaining),
    .stock500  (stock500),
    .stock100  (stock100)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (coin500 && !p500) n500++;
    if (coin100 && !p100) n100++;
    if (done) ndone++;
    if (coin500 && coin100) nboth++;
    if (busy) nbusy++;
    p500 = coin500;
    p100 = coin100;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Leaves the bench one cycle after the accepted start edge ("cycle 1").
  task automatic start_payout(input logic [W-1:0] amt);
    start  = 1'b1;
    amount = amt;
    step();
    start  = 1'b0;
    amount = 8'hAA;
  endtask

  task automatic wait_end(input string name, input int budget);
    int cyc = 0;
    while (!(done || fault) && cyc < budget) begin
      step();
      cyc++;
    end
    checks++;
    if (!(done || fault)) begin
      failures++;
      $display("FAIL %s timeout: done=%0b fault=%0b after %0d cycles, required done or fault", name, done, fault, cyc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({coin500, coin100, busy, done, fault} !== 5'b0 || remaining !== 8'd0 ||
        stock500 !== 8'd10 || stock100 !== 8'd20) begin
      failures++;
      $display("FAIL reset_state: c500=%0b c100=%0b busy=%0b done=%0b fault=%0b rem=%0d s500=%0d s100=%0d, required 0 0 0 0 0 0 10 20",
               coin500, coin100, busy, done, fault, remaining, stock500, stock100);
    end
    $display("reset: rem=%0d s500=%0d s100=%0d", remaining, stock500, stock100);
  endtask

  task automatic test_amount6();
    logic [3:0] exp_v;
    do_reset();
    start_payout(8'd6);
    for (int k = 1; k <= 13; k++) begin
      exp_v[3] = (k == 2 || k == 3);
      exp_v[2] = (k == 8 || k == 9);
      exp_v[1] = (k <= 12);
      exp_v[0] = (k == 13);
      checks++;
      if ({coin500, coin100, busy, done} !== exp_v) begin
        failures++;
        $display("FAIL amount6_cycle%0d: {c500,c100,busy,done}=%b, required %b", k, {coin500, coin100, busy, done}, exp_v);
      end
      step();
    end
    checks++;
    if (remaining !== 8'd0 || stock500 !== 8'd9 || stock100 !== 8'd19) begin
      failures++;
      $display("FAIL amount6_final: rem=%0d s500=%0d s100=%0d, required 0 9 19", remaining, stock500, stock100);
    end
    $display("amount=6: rem=%0d s500=%0d s100=%0d", remaining, stock500, stock100);
  endtask

  task automatic test_zero();
    int b0, s0, h0;
    do_reset();
    b0 = nbusy; s0 = n500 + n100;
    start_payout(8'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_done: done=%0b busy=%0b in cycle 1, required 1 0", done, busy);
    end
    step();
    step();
    h0 = n500 + n100;
    checks++;
    if (nbusy != b0 || h0 != s0 || done !== 1'b0) begin
      failures++;
      $display("FAIL zero_quiet: busy cycles=%0d strobes=%0d done=%0b, required 0 0 0", nbusy - b0, h0 - s0, done);
    end
    $display("amount=0: done seen, busy cycles=%0d", nbusy - b0);
  endtask

  task automatic test_drain500_fault();
    int a5, a1, ad;
    do_reset();
    start_payout(8'd45);
    wait_end("drain45", 200);
    step();
    checks++;
    if (stock500 !== 8'd1 || stock100 !== 8'd20) begin
      failures++;
      $display("FAIL drain45_stock: s500=%0d s100=%0d, required 1 20", stock500, stock100);
    end
    a5 = n500; a1 = n100; ad = ndone;
    start_payout(8'd11);
    step();
    checks++;
    if (coin500 !== 1'b1 || coin100 !== 1'b0) begin
      failures++;
      $display("FAIL amt11_first: c500=%0b c100=%0b, required 1 0", coin500, coin100);
    end
    wait_end("amt11", 200);
    step();
    checks++;
    if (n500 - a5 != 1 || n100 - a1 != 6 || ndone - ad != 1 || stock500 !== 8'd0 ||
        stock100 !== 8'd14 || remaining !== 8'd0) begin
      failures++;
      $display("FAIL amt11_final: n500=%0d n100=%0d ndone=%0d s500=%0d s100=%0d rem=%0d, required 1 6 1 0 14 0",
               n500 - a5, n100 - a1, ndone - ad, stock500, stock100, remaining);
    end
    $display("amount=11: n500=%0d n100=%0d s500=%0d s100=%0d", n500 - a5, n100 - a1, stock500, stock100);

    start_payout(8'd12);
    wait_end("amt12", 300);
    step();
    a1 = n100;
    start_payout(8'd4);
    wait_end("amt4", 100);
    checks++;
    if (fault !== 1'b1 || busy !== 1'b0 || remaining !== 8'd2 || stock100 !== 8'd0 || n100 - a1 != 2) begin
      failures++;
      $display("FAIL amt4_fault: fault=%0b busy=%0b rem=%0d s100=%0d n100=%0d, required 1 0 2 0 2",
               fault, busy, remaining, stock100, n100 - a1);
    end
    start = 1'b1; restock = 1'b1; amount = 8'd3;
    step();
    start = 1'b0; restock = 1'b0;
    step();
    checks++;
    if (fault !== 1'b1 || remaining !== 8'd2 || stock500 !== 8'd0 || stock100 !== 8'd0) begin
      failures++;
      $display("FAIL fault_hold: fault=%0b rem=%0d s500=%0d s100=%0d, required 1 2 0 0", fault, remaining, stock500, stock100);
    end
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b0 || remaining !== 8'd0) begin
      failures++;
      $display("FAIL fault_clr: fault=%0b rem=%0d, required 0 0", fault, remaining);
    end
    start_payout(8'd0);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL after_clr_start: done=%0b, required 1", done);
    end
    step();
    $display("fault path: cleared, new start accepted");
  endtask

  task automatic test_reset_mid_strobe();
    do_reset();
    start_payout(8'd6);
    step();
    checks++;
    if (coin500 !== 1'b1) begin
      failures++;
      $display("FAIL midstrobe_pre: c500=%0b in cycle 2, required 1", coin500);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (coin500 !== 1'b0 || busy !== 1'b0 || remaining !== 8'd0 || stock500 !== 8'd10 || stock100 !== 8'd20) begin
      failures++;
      $display("FAIL midstrobe_rst: c500=%0b busy=%0b rem=%0d s500=%0d s100=%0d, required 0 0 0 10 20",
               coin500, busy, remaining, stock500, stock100);
    end
    $display("reset mid-strobe: c500=%0b busy=%0b", coin500, busy);
  endtask

  task automatic test_back_to_back();
    int a5, a1;
    do_reset();
    a5 = n500; a1 = n100;
    start_payout(8'd6);
    step();
    start = 1'b1; amount = 8'd20;
    step();
    start = 1'b0;
    step();
    start = 1'b1; restock = 1'b1;
    step();
    start = 1'b0; restock = 1'b0;
    wait_end("busy_ignore", 100);
    step();
    checks++;
    if (n500 - a5 != 1 || n100 - a1 != 1 || remaining !== 8'd0 || stock500 !== 8'd9 || stock100 !== 8'd19) begin
      failures++;
      $display("FAIL busy_ignore: n500=%0d n100=%0d rem=%0d s500=%0d s100=%0d, required 1 1 0 9 19",
               n500 - a5, n100 - a1, remaining, stock500, stock100);
    end
    start = 1'b1; restock = 1'b1; amount = 8'd0;
    step();
    start = 1'b0; restock = 1'b0;
    checks++;
    if (done !== 1'b1 || stock500 !== 8'd9 || stock100 !== 8'd19) begin
      failures++;
      $display("FAIL start_wins: done=%0b s500=%0d s100=%0d, required 1 9 19", done, stock500, stock100);
    end
    step();
    restock = 1'b1;
    step();
    restock = 1'b0;
    checks++;
    if (stock500 !== 8'd10 || stock100 !== 8'd20) begin
      failures++;
      $display("FAIL restock: s500=%0d s100=%0d, required 10 20", stock500, stock100);
    end
    checks++;
    if (nboth != 0) begin
      failures++;
      $display("FAIL both_strobes: overlap cycles=%0d, required 0", nboth);
    end
    $display("back-to-back: s500=%0d s100=%0d", stock500, stock100);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; amount = '0; restock = 1'b0; fault_clr = 1'b0;
    test_reset();
    test_amount6();
    test_zero();
    test_drain500_fault();
    test_reset_mid_strobe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
